vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM (on-chip, 1-cycle read latency) between the VGA scanout fetcher and the Z80 CPU bus.
- Runs in the clock_25 domain driven by the PLL 25 MHz output. Reset is derived from PLL `locked`.
- Video has absolute priority and fixed 1-cycle latency. The CPU uses a level req / pulse ack handshake and is stalled while video occupies the port.

---
 rtl/vram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between video scanout (absolute priority) and the CPU bus.
// Optional one-entry posted write buffer: define VRAM_ARB_POSTED_WRITE_EN.
module vram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 8,
    parameter int SW = 16
) (
    input  logic          clock_25,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    input  logic          stall_clr,
    output logic [SW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RDWAIT,
        ACK
    } state_t;

    state_t        state_reg;
    logic          vid_valid_reg;
    logic [DW-1:0] cpu_rdata_reg;
    logic          cpu_ack_reg;
    logic [SW-1:0] stall_cnt_reg;

    logic          cpu_issue;
    logic          cpu_stall;

`ifdef VRAM_ARB_POSTED_WRITE_EN
    logic          wb_valid_reg;
    logic [AW-1:0] wb_addr_reg;
    logic [DW-1:0] wb_data_reg;
    logic          wb_drain;
    logic          wb_capture;
    logic          wb_forward;

    // cpu_issue means a RAM read here; writes always go through the buffer.
    always_comb begin
        wb_drain   = wb_valid_reg && !vid_req;
        wb_capture = (state_reg == IDLE) && cpu_req && cpu_we && !wb_valid_reg;
        wb_forward = (state_reg == IDLE) && cpu_req && !cpu_we && wb_valid_reg
                     && (cpu_addr == wb_addr_reg);
        cpu_issue  = (state_reg == IDLE) && cpu_req && !cpu_we && !wb_valid_reg && !vid_req;
        cpu_stall  = (state_reg == IDLE) && cpu_req && !(wb_capture || wb_forward || cpu_issue);
    end
`else
    always_comb begin
        cpu_issue = (state_reg == IDLE) && cpu_req && !vid_req;
        cpu_stall = (state_reg == IDLE) && cpu_req && vid_req;
    end
`endif

    // Port mux: video first, then the CPU slot; the idle address follows video.
    always_comb begin
        ram_addr  = vid_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        if (!vid_req) begin
`ifdef VRAM_ARB_POSTED_WRITE_EN
            if (wb_drain) begin
                ram_addr  = wb_addr_reg;
                ram_wdata = wb_data_reg;
                ram_we    = 1'b1;
            end else if (cpu_issue) begin
                ram_addr = cpu_addr;
            end
`else
            if (cpu_issue) begin
                ram_addr = cpu_addr;
                ram_we   = cpu_we;
            end
`endif
        end
        if (!reset_n) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            vid_valid_reg <= 1'b0;
            cpu_rdata_reg <= '0;
            cpu_ack_reg   <= 1'b0;
            stall_cnt_reg <= '0;
`ifdef VRAM_ARB_POSTED_WRITE_EN
            wb_valid_reg  <= 1'b0;
            wb_addr_reg   <= '0;
            wb_data_reg   <= '0;
`endif
        end else begin
            vid_valid_reg <= vid_req;
            cpu_ack_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cpu_issue) begin
                        state_reg   <= cpu_we ? ACK : RDWAIT;
                        cpu_ack_reg <= cpu_we;
                    end
`ifdef VRAM_ARB_POSTED_WRITE_EN
                    else if (wb_capture) begin
                        state_reg   <= ACK;
                        cpu_ack_reg <= 1'b1;
                    end else if (wb_forward) begin
                        cpu_rdata_reg <= wb_data_reg;
                        state_reg     <= ACK;
                        cpu_ack_reg   <= 1'b1;
                    end
`endif
                end
                RDWAIT: begin
                    cpu_rdata_reg <= ram_q;
                    cpu_ack_reg   <= 1'b1;
                    state_reg     <= ACK;
                end
                ACK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

`ifdef VRAM_ARB_POSTED_WRITE_EN
            // Capture needs an empty buffer and drain needs a full one, so they never collide.
            if (wb_capture) begin
                wb_valid_reg <= 1'b1;
                wb_addr_reg  <= cpu_addr;
                wb_data_reg  <= cpu_wdata;
            end else if (wb_drain) begin
                wb_valid_reg <= 1'b0;
            end
`endif

            if (stall_clr) begin
                stall_cnt_reg <= '0;
            end else if (cpu_stall && (stall_cnt_reg != {SW{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign vid_valid = vid_valid_reg;
    assign vid_data  = vid_valid_reg ? ram_q : '0;
    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_ack   = cpu_ack_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic          stall_clr;
    logic [SW-1:0] stall_cnt;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] vexp [4];

    int total = 0;
    int bad   = 0;

    vram_arbiter #(.AW(AW), .DW(DW), .SW(SW)) dut (
        .clock_25  (clk),
        .reset_n   (reset_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[14'h0101] = 8'h5A;
        vexp[0] = 8'h11; vexp[1] = 8'h22; vexp[2] = 8'h33; vexp[3] = 8'h44;
        ram_q = '0;

        // reset with a write request pending: RAM must stay untouched
        reset_n = 1'b0; vid_req = 1'b0; vid_addr = '0; stall_clr = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0002; cpu_wdata = 8'hEE;
        tick(); tick();
        check("rst_vid_valid", vid_valid, 0);
        check("rst_vid_data", vid_data, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_mem_untouched", mem[2], 8'h33);
        cpu_req = 1'b0; cpu_we = 1'b0;
        reset_n = 1'b1;
        tick();
        $display("txn reset done");

        // write 0x3A5 <= 0x5C, then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h03A5; cpu_wdata = 8'h5C;
        #1;
`ifndef VRAM_ARB_POSTED_WRITE_EN
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 14'h03A5);
        check("wr_ram_wdata", ram_wdata, 8'h5C);
`endif
        tick();
        check("wr_ack_t1", cpu_ack, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        check("wr_ack_pulse", cpu_ack, 0);
        check("wr_mem", mem[14'h03A5], 8'h5C);
        $display("txn write 3a5 <= 5c ack=1");
        cpu_req = 1'b1; cpu_addr = 14'h03A5;
        #1;
        check("rd_ram_addr", ram_addr, 14'h03A5);
        check("rd_ram_we", ram_we, 0);
        tick();
        check("rd_ack_t1", cpu_ack, 0);
        tick();
        check("rd_ack_t2", cpu_ack, 1);
        check("rd_data", cpu_rdata, 8'h5C);
        cpu_req = 1'b0;
        tick();
        $display("txn read 3a5 -> %0h", cpu_rdata);

        // 10 cycles of video with a pending CPU read
        vid_req = 1'b1; vid_addr = 14'h03A5; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0002;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stl_ram_addr", ram_addr, 14'h03A5);
            check("stl_ram_we", ram_we, 0);
            tick();
            check("stl_vid_valid", vid_valid, 1);
            check("stl_vid_data", vid_data, 8'h5C);
            check("stl_no_ack", cpu_ack, 0);
        end
        check("stl_cnt10", stall_cnt, 10);
        vid_req = 1'b0;
        #1;
        check("stl_issue_addr", ram_addr, 14'h0002);
        tick();
        check("stl_vid_drop", vid_valid, 0);
        check("stl_ack_early", cpu_ack, 0);
        tick();
        check("stl_ack", cpu_ack, 1);
        check("stl_data", cpu_rdata, 8'h33);
        check("stl_cnt_hold", stall_cnt, 10);
        cpu_req = 1'b0;
        tick();
        $display("txn stalled read 0002 -> %0h stalls=%0d", cpu_rdata, stall_cnt);

        // back-to-back video fetches
        vid_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vid_addr = AW'(i);
            tick();
            check("vid_valid_b2b", vid_valid, 1);
            check("vid_data_b2b", vid_data, vexp[i]);
            $display("txn video %0d -> %0h", i, vid_data);
        end
        vid_req = 1'b0;
        tick();
        check("vid_valid_end", vid_valid, 0);
        check("vid_data_end", vid_data, 0);

        // stall counter saturation and clear priority
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("sat_clr", stall_cnt, 0);
        vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0001;
        repeat (65534) tick();
        check("sat_fffe", stall_cnt, 16'hFFFE);
        repeat (3) tick();
        check("sat_ffff", stall_cnt, 16'hFFFF);
        stall_clr = 1'b1;
        tick();
        check("sat_clr_prio", stall_cnt, 0);
        stall_clr = 1'b0;
        tick();
        check("sat_restart", stall_cnt, 1);
        vid_req = 1'b0; cpu_req = 1'b0;
        tick();
        $display("txn stall counter saturate/clear done");

        // reset during RDWAIT abandons the read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0003;
        tick();
        check("rrw_ack0", cpu_ack, 0);
        reset_n = 1'b0;
        #1;
        check("rrw_stall_cnt", stall_cnt, 0);
        check("rrw_ram_we", ram_we, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rrw_no_ack", cpu_ack, 0);
            check("rrw_rdata", cpu_rdata, 0);
            check("rrw_vid_valid", vid_valid, 0);
        end
        cpu_req = 1'b0;
        reset_n = 1'b1;
        tick();
        check("rrw_after_ack", cpu_ack, 0);
        cpu_req = 1'b1;
        tick();
        tick();
        check("rrw_new_ack", cpu_ack, 1);
        check("rrw_new_data", cpu_rdata, 8'h44);
        cpu_req = 1'b0;
        tick();
        $display("txn reset in rdwait, then read 0003 -> %0h", cpu_rdata);

`ifndef VRAM_ARB_POSTED_WRITE_EN
        // a write committed on the edge before reset survives it
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'h77;
        tick();
        reset_n = 1'b0;
        #1;
        check("rwr_ack_cut", cpu_ack, 0);
        check("rwr_mem", mem[14'h0010], 8'h77);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        $display("txn write before reset kept: %0h", mem[14'h0010]);
`endif

`ifdef VRAM_ARB_POSTED_WRITE_EN
        // posted write under continuous video, forward hit, then miss that waits for drain
        vid_req = 1'b1; vid_addr = 14'h0000;
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'hAB;
        #1;
        check("pw_no_ram_we", ram_we, 0);
        tick();
        check("pw_ack", cpu_ack, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_addr = 14'h0100;
        tick();
        check("pw_fwd_ack", cpu_ack, 1);
        check("pw_fwd_data", cpu_rdata, 8'hAB);
        cpu_req = 1'b0;
        tick();
        check("pw_mem_pending", mem[14'h0100], 8'h00);
        cpu_req = 1'b1; cpu_addr = 14'h0101;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pw_miss_wait", cpu_ack, 0);
        end
        vid_req = 1'b0;
        #1;
        check("pw_drain_we", ram_we, 1);
        check("pw_drain_addr", ram_addr, 14'h0100);
        check("pw_drain_data", ram_wdata, 8'hAB);
        tick();
        check("pw_rd_addr", ram_addr, 14'h0101);
        check("pw_mem_drained", mem[14'h0100], 8'hAB);
        tick();
        check("pw_rd_wait", cpu_ack, 0);
        tick();
        check("pw_rd_ack", cpu_ack, 1);
        check("pw_rd_data", cpu_rdata, 8'h5A);
        check("pw_stalls", stall_cnt, 4);
        cpu_req = 1'b0;
        tick();
        $display("txn posted write 0100 <= ab, read 0101 -> %0h", cpu_rdata);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
